// File: rtl/gtype_pkg.sv
// Shared types for the 10GBASE-R link bring-up sequencer.
// State encoding is visible on the status port, so values are fixed.
package gtype;

    localparam int LINK_STATE_W = 3;

    typedef enum logic [LINK_STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_RESET      = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_WAIT_LOCK  = 3'd3,
        ST_DEBOUNCE   = 3'd4,
        ST_LINK_UP    = 3'd5,
        ST_DOWN       = 3'd6,
        ST_FAIL       = 3'd7
    } link_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/baser_debounce.sv
// Consecutive-sample run counters for a single synchronised level.
// done flags fire on the N-th consecutive sample of the run.
module baser_debounce #(
    parameter int HI_N = 1024,
    parameter int LO_N = 4
) (
    input  logic clk_glbl,
    input  logic rst_glbl,
    input  logic in,
    input  logic clr,
    output logic high_cnt_done,
    output logic low_cnt_done
);

    localparam int HW = $clog2(HI_N + 1);
    localparam int LW = $clog2(LO_N + 1);
    localparam logic [HW-1:0] HI_LAST = HW'(HI_N - 1);
    localparam logic [LW-1:0] LO_LAST = LW'(LO_N - 1);

    logic [HW-1:0] hi_cnt;
    logic [LW-1:0] lo_cnt;

    always_ff @(posedge clk_glbl) begin
        if (rst_glbl || clr) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            if (!in)
                hi_cnt <= '0;
            else if (hi_cnt != HI_LAST)
                hi_cnt <= hi_cnt + 1'b1;
            if (in)
                lo_cnt <= '0;
            else if (lo_cnt != LO_LAST)
                lo_cnt <= lo_cnt + 1'b1;
        end
    end

    assign high_cnt_done = in && !clr && (hi_cnt == HI_LAST);
    assign low_cnt_done  = !in && !clr && (lo_cnt == LO_LAST);

endmodule

// File: rtl/baser_link_ctrl.sv
// 10GBASE-R link bring-up and recovery sequencer on clk_glbl.
// Drives transceiver reset, qualifies lock and retrains on loss.
module baser_link_ctrl
    import gtype::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int UP_DEBOUNCE   = 1024,
    parameter int DOWN_DEBOUNCE = 4,
    parameter int MAX_RETRIES   = 0,
    parameter int CNT_W         = 32
) (
    input  logic        clk_glbl,
    input  logic        rst_glbl,
    input  logic        enable,
    input  logic        retrain_req,
    input  logic        tx_ready,
    input  logic        rx_ready,
    input  logic        rx_sync,
    output logic        xcvr_rst,
    output logic        link_up,
    output logic        tx_force_idle,
    output logic [2:0]  state,
    output logic [7:0]  retry_cnt,
    output logic [15:0] flap_cnt,
    output logic        fail
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    link_state_t      st;
    link_state_t      nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_keep;
    logic [7:0]       retry_nxt;
    logic [15:0]      flap_nxt;
    logic             hi_done;
    logic             lo_done;
    logic             dbc_clr;

    assign dbc_clr = !(st == ST_DEBOUNCE || st == ST_LINK_UP);

    baser_debounce #(
        .HI_N(UP_DEBOUNCE),
        .LO_N(DOWN_DEBOUNCE)
    ) u_sync_dbc (
        .clk_glbl     (clk_glbl),
        .rst_glbl     (rst_glbl),
        .in           (rx_sync),
        .clr          (dbc_clr),
        .high_cnt_done(hi_done),
        .low_cnt_done (lo_done)
    );

    // cnt is one window across WAIT_READY, WAIT_LOCK and DEBOUNCE,
    // so lock bounces cannot stretch the attempt past LOCK_TIMEOUT.
    always_comb begin
        nxt       = st;
        cnt_keep  = 1'b0;
        retry_nxt = retry_cnt;
        flap_nxt  = flap_cnt;
        if (!enable) begin
            nxt = ST_IDLE;
            if (st == ST_FAIL)
                retry_nxt = '0;
        end else if (retrain_req && st != ST_IDLE) begin
            nxt = ST_RESET;
            if (st == ST_FAIL)
                retry_nxt = '0;
            if (st == ST_LINK_UP)
                flap_nxt = sat_inc16(flap_cnt);
        end else begin
            unique case (st)
                ST_IDLE: nxt = ST_RESET;
                ST_RESET: begin
                    if (cnt == RST_LAST)
                        nxt = ST_WAIT_READY;
                    else
                        cnt_keep = 1'b1;
                end
                ST_WAIT_READY, ST_WAIT_LOCK, ST_DEBOUNCE: begin
                    if (cnt == TO_LAST) begin
                        retry_nxt = sat_inc8(retry_cnt);
                        nxt = (MAX_RETRIES != 0 &&
                               int'(retry_nxt) >= MAX_RETRIES)
                            ? ST_FAIL : ST_RESET;
                    end else begin
                        cnt_keep = 1'b1;
                        if (st == ST_WAIT_READY) begin
                            if (tx_ready && rx_ready)
                                nxt = ST_WAIT_LOCK;
                        end else if (st == ST_WAIT_LOCK) begin
                            if (rx_sync)
                                nxt = ST_DEBOUNCE;
                        end else if (!rx_sync) begin
                            nxt = ST_WAIT_LOCK;
                        end else if (hi_done) begin
                            nxt       = ST_LINK_UP;
                            cnt_keep  = 1'b0;
                            retry_nxt = '0;
                        end
                    end
                end
                ST_LINK_UP: begin
                    if (!rx_ready || lo_done) begin
                        nxt      = ST_DOWN;
                        flap_nxt = sat_inc16(flap_cnt);
                    end
                end
                ST_DOWN: nxt = ST_RESET;
                ST_FAIL: nxt = ST_FAIL;
                default: nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_glbl) begin
        if (rst_glbl) begin
            st            <= ST_IDLE;
            cnt           <= '0;
            retry_cnt     <= '0;
            flap_cnt      <= '0;
            xcvr_rst      <= 1'b1;
            link_up       <= 1'b0;
            tx_force_idle <= 1'b1;
            fail          <= 1'b0;
        end else begin
            st            <= nxt;
            cnt           <= cnt_keep ? cnt + 1'b1 : '0;
            retry_cnt     <= retry_nxt;
            flap_cnt      <= flap_nxt;
            xcvr_rst      <= (nxt == ST_IDLE) || (nxt == ST_RESET) ||
                             (nxt == ST_FAIL);
            link_up       <= (nxt == ST_LINK_UP);
            tx_force_idle <= (nxt != ST_LINK_UP);
            fail          <= (nxt == ST_FAIL);
        end
    end

    assign state = st;

endmodule
